// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// One SEG_WIDTH-bit segment is resolved per stage. The carry, the running group
// propagate/generate and the partial sum are registered between stages.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    input handshake; in0/in1/carry_in/sub are the operands
//   out_valid/out_ready  output handshake; sum/carry_out/overflow/PG/GG are the result
module pipelined_cla_adder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SEG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             PG,
  output logic             GG
);

  localparam int unsigned NSEG = WIDTH / SEG_WIDTH;
  localparam int unsigned NGRP = SEG_WIDTH / 4;

  // Global stall: the whole pipeline freezes while the output beat is refused.
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Input register: operand A, prepared operand B' and carry into bit 0.
  logic             v0_q, v0_d;
  logic [WIDTH-1:0] a0_q, a0_d;
  logic [WIDTH-1:0] b0_q, b0_d;
  logic             c0_q, c0_d;

  always_comb begin
    v0_d = v0_q;
    a0_d = a0_q;
    b0_d = b0_q;
    c0_d = c0_q;
    if (!stall) begin
      v0_d = in_valid;
      if (in_valid) begin
        a0_d = in0;
        b0_d = sub ? ~in1 : in1;
        c0_d = sub | carry_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      a0_q <= '0;
      b0_q <= '0;
      c0_q <= 1'b0;
    end else begin
      v0_q <= v0_d;
      a0_q <= a0_d;
      b0_q <= b0_d;
      c0_q <= c0_d;
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int unsigned LO = k * SEG_WIDTH;
    localparam int unsigned BW = WIDTH - LO;

    // acc holds sum bits below LO and still-unprocessed A bits from LO upward.
    logic             v_in, c_in, pg_in, gg_in;
    logic [WIDTH-1:0] acc_in;
    logic [BW-1:0]    b_in;

    logic             v_q, v_d, c_q, c_d, pg_q, pg_d, gg_q, gg_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [SEG_WIDTH-1:0] a_s, b_s, p, g, s_seg;
    logic [SEG_WIDTH:0]   c;
    logic [NGRP:0]        sp, sg;

    if (k == 0) begin : g_src
      assign v_in   = v0_q;
      assign acc_in = a0_q;
      assign b_in   = b0_q;
      assign c_in   = c0_q;
      assign pg_in  = 1'b1;
      assign gg_in  = 1'b0;
    end else begin : g_src
      assign v_in   = g_stage[k-1].v_q;
      assign acc_in = g_stage[k-1].acc_q;
      assign b_in   = g_stage[k-1].g_pass.b_q;
      assign c_in   = g_stage[k-1].c_q;
      assign pg_in  = g_stage[k-1].pg_q;
      assign gg_in  = g_stage[k-1].gg_q;
    end

    assign a_s   = acc_in[LO +: SEG_WIDTH];
    assign b_s   = b_in[SEG_WIDTH-1:0];
    assign p     = a_s ^ b_s;
    assign g     = a_s & b_s;
    assign c[0]  = c_in;
    assign sp[0] = 1'b1;
    assign sg[0] = 1'b0;

    // 4-bit lookahead groups; sp/sg fold group P/G into the segment P/G
    // without the incoming carry.
    for (genvar j = 0; j < NGRP; j++) begin : g_grp
      localparam int unsigned B = 4 * j;
      logic grp_p, grp_g;
      assign grp_p = &p[B +: 4];
      assign grp_g = g[B+3] | (p[B+3] & g[B+2]) | (&p[B+2 +: 2] & g[B+1])
                   | (&p[B+1 +: 3] & g[B]);
      assign c[B+1] = g[B] | (p[B] & c[B]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (&p[B +: 2] & c[B]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (&p[B+1 +: 2] & g[B])
                    | (&p[B +: 3] & c[B]);
      assign c[B+4] = grp_g | (grp_p & c[B]);
      assign sp[j+1] = sp[j] & grp_p;
      assign sg[j+1] = grp_g | (grp_p & sg[j]);
    end

    assign s_seg = p ^ c[SEG_WIDTH-1:0];

    // Data registers load only with a valid beat, so outputs hold across bubbles.
    always_comb begin
      v_d   = v_q;
      acc_d = acc_q;
      c_d   = c_q;
      pg_d  = pg_q;
      gg_d  = gg_q;
      if (!stall) begin
        v_d = v_in;
        if (v_in) begin
          acc_d                  = acc_in;
          acc_d[LO +: SEG_WIDTH] = s_seg;
          c_d                    = c[SEG_WIDTH];
          pg_d                   = pg_in & sp[NGRP];
          gg_d                   = sg[NGRP] | (sp[NGRP] & gg_in);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        acc_q <= '0;
        c_q   <= 1'b0;
        pg_q  <= 1'b0;
        gg_q  <= 1'b0;
      end else begin
        v_q   <= v_d;
        acc_q <= acc_d;
        c_q   <= c_d;
        pg_q  <= pg_d;
        gg_q  <= gg_d;
      end
    end

    if (k < NSEG - 1) begin : g_pass
      // Remaining B' slices shrink by one segment per stage.
      logic [BW-SEG_WIDTH-1:0] b_q, b_d;
      always_comb begin
        b_d = b_q;
        if (v_in && !stall) b_d = b_in[BW-1:SEG_WIDTH];
      end
      always_ff @(posedge clk) begin
        if (!rst_n) b_q <= '0;
        else        b_q <= b_d;
      end
    end else begin : g_last
      // Signed overflow: carry into the MSB differs from carry out of it.
      logic ov_q, ov_d;
      always_comb begin
        ov_d = ov_q;
        if (v_in && !stall) ov_d = c[SEG_WIDTH] ^ c[SEG_WIDTH-1];
      end
      always_ff @(posedge clk) begin
        if (!rst_n) ov_q <= 1'b0;
        else        ov_q <= ov_d;
      end
    end
  end

  assign out_valid = g_stage[NSEG-1].v_q;
  assign sum       = g_stage[NSEG-1].acc_q;
  assign carry_out = g_stage[NSEG-1].c_q;
  assign overflow  = g_stage[NSEG-1].g_last.ov_q;
  assign PG        = g_stage[NSEG-1].pg_q;
  assign GG        = g_stage[NSEG-1].gg_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed vector table on a
// 32/8 instance plus streaming, backpressure and reset sequences, and
// streaming checks on 16/4, 32/32 and 64/16 instances.
module tb_pipelined_cla_adder;

  localparam int unsigned W    = 32;
  localparam int unsigned S    = 8;
  localparam int unsigned NSEG = W / S;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, carry_in, sub, out_valid, out_ready;
  logic         carry_out, overflow, PG, GG;
  logic [W-1:0] in0, in1, sum;

  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    logic         pg;
    logic         gg;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sb;
    res_t         exp;
  } vec_t;

  res_t exp_q[$];
  vec_t vecs[12];

  pipelined_cla_adder #(.WIDTH(W), .SEG_WIDTH(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow), .PG(PG), .GG(GG)
  );

  function automatic vec_t mkv(input logic [W-1:0] a, b, input logic cin, sb,
                               input logic [W-1:0] s, input logic co, ov, pg, gg);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sb = sb;
    v.exp = {s, co, ov, pg, gg};
    return v;
  endfunction

  // Reference: (WIDTH+1)-bit addition of A, B' and c0.
  function automatic res_t model(input logic [W-1:0] a, b, input logic cin, sb);
    logic [W-1:0] bp;
    logic [W:0]   full, raw;
    res_t         r;
    bp     = sb ? ~b : b;
    full   = {1'b0, a} + {1'b0, bp} + (W+1)'(sb | cin);
    raw    = {1'b0, a} + {1'b0, bp};
    r.sum  = full[W-1:0];
    r.co   = full[W];
    r.ov   = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
    r.pg   = &(a ^ bp);
    r.gg   = raw[W];
    return r;
  endfunction

  function automatic res_t cur();
    return {sum, carry_out, overflow, PG, GG};
  endfunction

  task automatic check_res(input string nm, input res_t act, input res_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got sum=%h co=%b ov=%b pg=%b gg=%b, expected sum=%h co=%b ov=%b pg=%b gg=%b",
               nm, act.sum, act.co, act.ov, act.pg, act.gg,
               exp.sum, exp.co, exp.ov, exp.pg, exp.gg);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One clock of streaming traffic; transfers are decided from the values
  // settled just after the falling edge and take effect on the next rising edge.
  task automatic cycle(input logic iv, input logic [W-1:0] a, b, input logic ci, sb,
                       input logic ordy, output logic acc);
    @(negedge clk);
    in_valid = iv; in0 = a; in1 = b; carry_in = ci; sub = sb; out_ready = ordy;
    #1;
    acc = iv & in_ready;
    if (acc) exp_q.push_back(model(a, b, ci, sb));
    if (out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL stream_extra: unexpected beat sum=%h", sum);
      end else begin
        check_res("stream", cur(), exp_q.pop_front());
      end
    end
  endtask

  // Single isolated beat: checks latency and the hand-computed result.
  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in0 = v.a; in1 = v.b; carry_in = v.cin; sub = v.sb; out_ready = 1'b1;
    #1;
    check_val({nm, "_in_ready"}, int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      #1;
      if (out_valid) break;
      @(negedge clk);
      lat++;
    end
    check_val({nm, "_latency"}, lat, NSEG);
    check_res(nm, cur(), v.exp);
  endtask

  task automatic drain(input int budget);
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      n++;
    end
    check_val("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   calls, stalls, nacc, ir_bad, st_bad, seen, p0, guard;
    res_t snap;
    logic [W-1:0] ra, rb;

    vecs[0]  = mkv(32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 0, 1);
    vecs[1]  = mkv(32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0, 1);
    vecs[2]  = mkv(32'h0F0F0F0F, 32'hF0F0F0F0, 1, 0, 32'h00000000, 1, 0, 1, 0);
    vecs[3]  = mkv(32'h0F0F0F0F, 32'hF0F0F0F0, 0, 0, 32'hFFFFFFFF, 0, 0, 1, 0);
    vecs[4]  = mkv(32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0, 0);
    vecs[5]  = mkv(32'h00000005, 32'h00000007, 0, 1, 32'hFFFFFFFE, 0, 0, 0, 0);
    vecs[6]  = mkv(32'h12345678, 32'h9ABCDEF0, 0, 0, 32'hACF13568, 0, 0, 0, 0);
    vecs[7]  = mkv(32'h12345678, 32'h12345678, 0, 1, 32'h00000000, 1, 0, 1, 0);
    vecs[8]  = mkv(32'h00000000, 32'h00000000, 1, 0, 32'h00000001, 0, 0, 0, 0);
    vecs[9]  = mkv(32'h00000000, 32'h00000000, 0, 1, 32'h00000000, 1, 0, 1, 0);
    vecs[10] = mkv(32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 0, 1);
    vecs[11] = mkv(32'hFFFF0000, 32'h0000FFFF, 1, 0, 32'h00000000, 1, 0, 1, 0);

    // Reset with beats presented throughout.
    rst_n = 1'b0; in_valid = 1'b1; in0 = 32'h1; in1 = 32'h2; carry_in = 1'b0;
    sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_out_valid", int'(out_valid), 0);
    check_res("reset_outputs", cur(), '0);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_val("reset_in_ready", int'(in_ready), 1);
    seen = 0;
    repeat (NSEG + 3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("reset_no_output", seen, 0);

    // Directed vector table.
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back sweep of 0..15 x 0..15.
    calls = 0; stalls = 0; p0 = pops;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, W'(i / 16), W'(i % 16), 1'(i % 2), 1'((i / 2) % 2), 1'b1, acc);
      calls++;
      if (!acc) stalls++;
    end
    guard = 0;
    while (pops - p0 < 256 && guard < 50) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      calls++; guard++;
    end
    check_val("sweep_stalls", stalls, 0);
    check_val("sweep_cycles", calls, 256 + NSEG + 1);

    // Random full-rate stream.
    calls = 0; p0 = pops;
    for (int i = 0; i < 10000; i++) begin
      cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);
      calls++;
    end
    guard = 0;
    while (pops - p0 < 10000 && guard < 50) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      calls++; guard++;
    end
    check_val("random_cycles", calls, 10000 + NSEG + 1);

    // Backpressure: fill, hold 5 cycles, release.
    nacc = 0; guard = 0;
    do begin
      cycle(1'b1, 32'h1000_0000 + W'(nacc), 32'h0F00_0000 + W'(nacc * 3), 1'b1, 1'(nacc % 2), 1'b0, acc);
      if (acc) nacc++;
      guard++;
    end while (acc && guard < 20);
    check_val("fill_depth", nacc, NSEG + 1);
    snap = cur();
    ir_bad = 0; st_bad = 0;
    repeat (5) begin
      cycle(1'b1, 32'hDEAD_BEEF, 32'h1, 1'b0, 1'b0, 1'b0, acc);
      if (in_ready) ir_bad++;
      if (cur() !== snap || !out_valid) st_bad++;
    end
    check_val("stall_in_ready", ir_bad, 0);
    check_val("stall_stable", st_bad, 0);
    p0 = pops;
    drain(50);
    check_val("bp_delivered", pops - p0, NSEG + 1);

    // Random valid/ready toggling.
    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      cycle(1'($urandom), ra, rb, 1'($urandom), 1'($urandom), ($urandom % 4) != 0, acc);
    end
    drain(100);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h5555_0000 + W'(i), 32'h1, 1'b0, 1'b0, 1'b1, acc);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    seen = 0;
    repeat (NSEG + 3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("midreset_no_output", seen, 0);
    run_vec(vecs[6], "post_reset");

    // Wait for the other configurations.
    guard = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check_val("cfg_complete", int'(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Parameter sweep: 16/4, 32/32 (single stage), 64/16.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int unsigned CW = (gi == 0) ? 16 : (gi == 1) ? 32 : 64;
    localparam int unsigned CS = (gi == 0) ? 4  : (gi == 1) ? 32 : 16;
    localparam int unsigned CN = CW / CS;

    logic          c_rst_n, c_iv, c_ir, c_ci, c_sb, c_ovld, c_or, c_co, c_ovf, c_pg, c_gg;
    logic [CW-1:0] c_a, c_b, c_sum;
    logic [CW+1:0] q[$];
    logic          done = 1'b0;

    pipelined_cla_adder #(.WIDTH(CW), .SEG_WIDTH(CS)) u_dut (
      .clk(clk), .rst_n(c_rst_n), .in_valid(c_iv), .in_ready(c_ir),
      .in0(c_a), .in1(c_b), .carry_in(c_ci), .sub(c_sb),
      .out_valid(c_ovld), .out_ready(c_or), .sum(c_sum),
      .carry_out(c_co), .overflow(c_ovf), .PG(c_pg), .GG(c_gg)
    );

    initial begin
      int            sent, rcvd, lat, guard;
      logic [CW-1:0] bp;
      logic [CW:0]   full;
      logic          ovf;
      logic [CW+1:0] e;

      c_rst_n = 1'b0; c_iv = 1'b0; c_or = 1'b1; c_a = '0; c_b = '0; c_ci = 1'b0; c_sb = 1'b0;
      repeat (2) @(negedge clk);
      c_rst_n = 1'b1;

      // All-ones + 1: carry ripples through every segment.
      @(negedge clk);
      c_iv = 1'b1; c_a = '1; c_b = CW'(1);
      @(negedge clk);
      c_iv = 1'b0; lat = 0;
      while (lat < 20) begin
        #1;
        if (c_ovld) break;
        @(negedge clk);
        lat++;
      end
      n_tests++;
      if (lat != CN || c_sum !== '0 || c_co !== 1'b1 || c_ovf !== 1'b0 || c_pg !== 1'b0 || c_gg !== 1'b1) begin
        n_fail++;
        $display("FAIL cfg%0d_carry_chain: lat=%0d sum=%h co=%b ov=%b pg=%b gg=%b, expected lat=%0d sum=0 co=1 ov=0 pg=0 gg=1",
                 gi, lat, c_sum, c_co, c_ovf, c_pg, c_gg, CN);
      end

      sent = 0; rcvd = 0; guard = 0;
      while (rcvd < 300 && guard < 4000) begin
        @(negedge clk);
        c_iv = (sent < 300) && (($urandom % 4) != 0);
        c_or = ($urandom % 4) != 0;
        c_a  = CW'({$urandom, $urandom});
        c_b  = CW'({$urandom, $urandom});
        c_ci = 1'($urandom);
        c_sb = 1'($urandom);
        #1;
        if (c_iv && c_ir) begin
          bp   = c_sb ? ~c_b : c_b;
          full = {1'b0, c_a} + {1'b0, bp} + (CW+1)'(c_sb | c_ci);
          ovf  = (c_a[CW-1] == bp[CW-1]) && (full[CW-1] != c_a[CW-1]);
          q.push_back({ovf, full});
          sent++;
        end
        if (c_ovld && c_or) begin
          rcvd++;
          n_tests++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL cfg%0d_extra: unexpected beat sum=%h", gi, c_sum);
          end else begin
            e = q.pop_front();
            if ({c_ovf, c_co, c_sum} !== e) begin
              n_fail++;
              $display("FAIL cfg%0d_stream: got ov=%b co=%b sum=%h, expected ov=%b co=%b sum=%h",
                       gi, c_ovf, c_co, c_sum, e[CW+1], e[CW], e[CW-1:0]);
            end
          end
        end
        guard++;
      end
      n_tests++;
      if (rcvd != 300 || q.size() != 0) begin
        n_fail++;
        $display("FAIL cfg%0d_count: received %0d with %0d pending, expected 300 with 0 pending",
                 gi, rcvd, q.size());
      end
      c_iv = 1'b0;
      done = 1'b1;
    end
  end

endmodule
